// File: rtl/piano_tiles_pkg.sv
// Shared types and constants for the piano tiles VGA write path.
// Holds the arbiter state encoding, requester indices and coordinate widths.
package piano_tiles_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_t;

   localparam logic [1:0] REQ_CLEAR = 2'd0;
   localparam logic [1:0] REQ_TILE  = 2'd1;
   localparam logic [1:0] REQ_SCORE = 2'd2;

   localparam int X_W   = 8;
   localparam int Y_W   = 7;
   localparam int COL_W = 3;

   function automatic logic [2:0] req_onehot(input logic [1:0] idx);
      logic [2:0] oh;
      oh = 3'b000;
      case (idx)
         REQ_CLEAR: oh = 3'b001;
         REQ_TILE:  oh = 3'b010;
         REQ_SCORE: oh = 3'b100;
         default:   oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Round-robin choice between the tile (1) and score (2) requesters.
// Returns the requester index, or REQ_CLEAR when neither is requesting.
module rr_pick2
   import piano_tiles_pkg::*;
(
   input  logic [1:0] i_req_lo,
   input  logic [1:0] i_rr_ptr,
   output logic [1:0] o_pick
);

   always_comb begin
      o_pick = REQ_CLEAR;
      if (i_rr_ptr == REQ_SCORE && i_req_lo[1])
         o_pick = REQ_SCORE;
      else if (i_rr_ptr == REQ_TILE && i_req_lo[0])
         o_pick = REQ_TILE;
      else if (i_req_lo[0])
         o_pick = REQ_TILE;
      else if (i_req_lo[1])
         o_pick = REQ_SCORE;
   end

endmodule

// File: rtl/vga_write_arbiter.sv
// Three-way arbiter for the VGA adapter write port: screen clear has priority,
// tile and score draws alternate, bursts of 1/2 are capped at MAX_BURST pixels.
//
// state    | meaning
// ST_IDLE  | no owner, sample req and pick a winner
// ST_GRANT | owner's pixels forwarded to the vga_* port
// ST_GAP   | one dead cycle after every burst end
module vga_write_arbiter
   import piano_tiles_pkg::*;
#(
   parameter int MAX_BURST = 160,
   parameter int NREQ      = 3
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       plot_in,
   input  logic [NREQ-1:0]       last_in,
   input  logic [NREQ*X_W-1:0]   x_in,
   input  logic [NREQ*Y_W-1:0]   y_in,
   input  logic [NREQ*COL_W-1:0] colour_in,
   output logic [NREQ-1:0]       gnt,
   output logic [X_W-1:0]        vga_x,
   output logic [Y_W-1:0]        vga_y,
   output logic [COL_W-1:0]      vga_colour,
   output logic                  vga_plot,
   output logic                  burst_cut
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   arb_state_t        r_state, w_state_nxt;
   logic [1:0]        r_owner, w_owner_nxt;
   logic [1:0]        r_rr_ptr, w_rr_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [2:0]        r_gnt, w_gnt_nxt;
   logic              r_plot, w_plot_nxt;
   logic              r_cut, w_cut_nxt;
   logic [X_W-1:0]    r_x;
   logic [Y_W-1:0]    r_y;
   logic [COL_W-1:0]  r_col;

   logic [1:0]        w_pick, w_win;
   logic              w_req_g, w_plot_g, w_last_g;
   logic              w_at_limit, w_burst_end;
   logic [X_W-1:0]    w_x_g;
   logic [Y_W-1:0]    w_y_g;
   logic [COL_W-1:0]  w_col_g;

   rr_pick2 u_rr_pick2 (
      .i_req_lo (req[2:1]),
      .i_rr_ptr (r_rr_ptr),
      .o_pick   (w_pick)
   );

   assign w_win = req[0] ? REQ_CLEAR : w_pick;

   always_comb begin
      w_x_g   = x_in[X_W-1:0];
      w_y_g   = y_in[Y_W-1:0];
      w_col_g = colour_in[COL_W-1:0];
      case (r_owner)
         REQ_TILE: begin
            w_x_g   = x_in[2*X_W-1:X_W];
            w_y_g   = y_in[2*Y_W-1:Y_W];
            w_col_g = colour_in[2*COL_W-1:COL_W];
         end
         REQ_SCORE: begin
            w_x_g   = x_in[3*X_W-1:2*X_W];
            w_y_g   = y_in[3*Y_W-1:2*Y_W];
            w_col_g = colour_in[3*COL_W-1:2*COL_W];
         end
         default: ;
      endcase
   end

   assign w_req_g  = req[r_owner];
   assign w_plot_g = plot_in[r_owner] & w_req_g;
   assign w_last_g = last_in[r_owner];

   // The limit fires on the pixel that brings the count up to MAX_BURST.
   assign w_at_limit  = (r_owner != REQ_CLEAR) && w_plot_g && (r_cnt == CNT_LAST);
   assign w_burst_end = !w_req_g || (w_plot_g && w_last_g) || w_at_limit;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state  <= ST_IDLE;
         r_owner  <= REQ_CLEAR;
         r_rr_ptr <= REQ_TILE;
         r_cnt    <= '0;
         r_gnt    <= '0;
         r_plot   <= 1'b0;
         r_cut    <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_col    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_owner  <= w_owner_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_cnt    <= w_cnt_nxt;
         r_gnt    <= w_gnt_nxt;
         r_plot   <= w_plot_nxt;
         r_cut    <= w_cut_nxt;
         if (r_state == ST_GRANT && w_plot_g) begin
            r_x   <= w_x_g;
            r_y   <= w_y_g;
            r_col <= w_col_g;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (|req) w_state_nxt = ST_GRANT;
         ST_GRANT: if (w_burst_end) w_state_nxt = ST_GAP;
         ST_GAP:   w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_owner_nxt = r_owner;
      w_rr_nxt    = r_rr_ptr;
      w_cnt_nxt   = r_cnt;
      w_gnt_nxt   = 3'b000;
      w_plot_nxt  = 1'b0;
      w_cut_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|req) begin
               w_owner_nxt = w_win;
               w_gnt_nxt   = req_onehot(w_win);
               w_cnt_nxt   = '0;
            end
         end
         ST_GRANT: begin
            w_gnt_nxt  = r_gnt;
            w_plot_nxt = w_plot_g;
            if (w_plot_g && r_cnt != CNT_MAX)
               w_cnt_nxt = r_cnt + 1'b1;
            if (w_burst_end) begin
               w_gnt_nxt = 3'b000;
               w_cut_nxt = w_at_limit && !w_last_g;
               if (r_owner != REQ_CLEAR)
                  w_rr_nxt = (r_owner == REQ_TILE) ? REQ_SCORE : REQ_TILE;
            end
         end
         default: ;
      endcase
   end

   assign gnt        = r_gnt;
   assign vga_plot   = r_plot;
   assign burst_cut  = r_cut;
   assign vga_x      = r_x;
   assign vga_y      = r_y;
   assign vga_colour = r_col;

endmodule
